// File: rtl/mon_trace_pkg.sv
// Shared definitions for the monitor trace buffer: geometry, FSM encoding, trace command codes.
`timescale 1ns/1ps
package mon_trace_pkg;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 18;
    localparam int DEPTH  = 2048;
    localparam int CNT_W  = 12;

    localparam logic [CNT_W-1:0]  WR_CNT_MAX = 12'd2048;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = 11'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WACK = 2'd1,
        DRD  = 2'd2,
        DOUT = 2'd3
    } state_t;

    typedef enum logic [3:0] {
        NORW = 4'h0,
        WCMD = 4'h1,
        WDAT = 4'h2,
        RDAT = 4'h3,
        WMEM = 4'h4,
        RMEM = 4'h5,
        OTHE = 4'h6
    } cmd_t;

    typedef struct packed {
        cmd_t        cmd;
        logic [13:0] payload;
    } trace_word_t;

    function automatic cmd_t trace_cmd(input logic [DATA_W-1:0] word);
        trace_word_t tw;
        tw = trace_word_t'(word);
        return tw.cmd;
    endfunction

endpackage

// File: rtl/mon_trace_buf_if.sv
// Host-write and dump-readout signal bundle; stall_cnt exists only with MON_STALL_CNT_EN.
`timescale 1ns/1ps
interface mon_trace_buf_if;
    import mon_trace_pkg::*;

    logic                wrreq;
    logic                wrack;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic                dump_start;
    logic                dump_busy;
    logic                dump_valid;
    logic                dump_ready;
    logic [ADDR_W-1:0]   dump_addr;
    logic [DATA_W-1:0]   dump_data;
    logic [CNT_W-1:0]    wr_cnt;
`ifdef MON_STALL_CNT_EN
    logic [7:0]          stall_cnt;
`endif

    modport master (
        output wrreq, waddr, wdata, dump_start, dump_ready,
        input  wrack, dump_busy, dump_valid, dump_addr, dump_data, wr_cnt
`ifdef MON_STALL_CNT_EN
        , input stall_cnt
`endif
    );

    modport slave (
        input  wrreq, waddr, wdata, dump_start, dump_ready,
        output wrack, dump_busy, dump_valid, dump_addr, dump_data, wr_cnt
`ifdef MON_STALL_CNT_EN
        , output stall_cnt
`endif
    );

endinterface

// File: rtl/mon_ram_2kx18.sv
// 2048x18 simple dual-port RAM: synchronous write, registered read with read enable.
`timescale 1ns/1ps
module mon_ram_2kx18
    import mon_trace_pkg::*;
(
    input  logic              clk,
    input  logic              rst_x,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the array has no reset so it maps onto block RAM and survives rst_x; only the read register clears.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_x) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mon_trace_buf.sv
// Trace buffer: acknowledged host writes into a 2Kx18 RAM plus a flow-controlled full readout.
// Optional MON_STALL_CNT_EN adds a saturating count of writes held off by a dump.
`timescale 1ns/1ps
module mon_trace_buf
    import mon_trace_pkg::*;
(
    input  logic           clk,
    input  logic           rst_x,
    mon_trace_buf_if.slave bus
);

    state_t            state_q, state_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [DATA_W-1:0] ram_rdata;

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        ptr_d    = ptr_q;
        wr_cnt_d = wr_cnt_q;

        if (bus.dump_start && (state_q == IDLE || state_q == WACK)) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.wrreq) begin
                    state_d = WACK;
                end else if (pend_q) begin
                    pend_d  = 1'b0;
                    ptr_d   = '0;
                    state_d = DRD;
                end
            end
            WACK: begin
                state_d = IDLE;
                if (wr_cnt_q != WR_CNT_MAX) begin
                    wr_cnt_d = wr_cnt_q + 12'd1;
                end
            end
            DRD: begin
                state_d = DOUT;
            end
            DOUT: begin
                if (bus.dump_ready) begin
                    if (ptr_q == LAST_ADDR) begin
                        state_d = IDLE;
                    end else begin
                        ptr_d   = ptr_q + 11'd1;
                        state_d = DRD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_x) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            ptr_q    <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            ptr_q    <= ptr_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    mon_ram_2kx18 u_ram (
        .clk     (clk),
        .rst_x   (rst_x),
        .we_i    (state_q == WACK),
        .waddr_i (bus.waddr),
        .wdata_i (bus.wdata),
        .re_i    (state_q == DRD),
        .raddr_i (ptr_q),
        .rdata_o (ram_rdata)
    );

    assign bus.wrack      = (state_q == WACK);
    assign bus.dump_busy  = (state_q == DRD) || (state_q == DOUT);
    assign bus.dump_valid = (state_q == DOUT);
    assign bus.dump_addr  = ptr_q;
    assign bus.dump_data  = ram_rdata;
    assign bus.wr_cnt     = wr_cnt_q;

`ifdef MON_STALL_CNT_EN
    logic       stalled_q, stalled_d;
    logic [7:0] stall_cnt_q, stall_cnt_d;

    // A request seen while a dump owns the RAM is remembered until its WACK.
    always_comb begin
        stalled_d   = stalled_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.wrreq && (state_q == DRD || state_q == DOUT)) begin
            stalled_d = 1'b1;
        end
        if (state_q == WACK) begin
            stalled_d = 1'b0;
            if (stalled_q && stall_cnt_q != 8'hFF) begin
                stall_cnt_d = stall_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_x) begin
            stalled_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            stalled_q   <= stalled_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mon_trace_buf.sv
// Self-checking bench for mon_trace_buf: reference RAM array, dump scoreboard queue, random data and flow control.
`timescale 1ns/1ps
module tb_mon_trace_buf;
    import mon_trace_pkg::*;

    logic clk = 1'b0;
    logic rst_x;
    always #5 clk = ~clk;

    mon_trace_buf_if bus ();

    mon_trace_buf dut (
        .clk   (clk),
        .rst_x (rst_x),
        .bus   (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int n_checks     = 0;
    int n_errors     = 0;
    int cyc_n        = 0;
    int model_wr_cnt = 0;
    int model_stall  = 0;

    always @(posedge clk) cyc_n++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted dump word must be the next one the model predicted.
    always @(negedge clk) begin
        if (rst_x === 1'b1 && bus.dump_valid === 1'b1 && bus.dump_ready === 1'b1) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                check("unexpected_dump_word", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("dump_addr", bus.dump_addr, e.addr);
                check("dump_data", bus.dump_data, e.data);
            end
        end
    end

    function automatic void model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                        input bit stalled);
        ref_mem[a] = d;
        if (model_wr_cnt < 2048) model_wr_cnt++;
        if (stalled && model_stall < 255) model_stall++;
    endfunction

    function automatic void push_snapshot();
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back('{addr: ADDR_W'(i), data: ref_mem[i]});
        end
    endfunction

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            output int waited, output int ack_cyc);
        @(posedge clk); #1;
        bus.wrreq = 1'b1;
        bus.waddr = a;
        bus.wdata = d;
        waited    = 0;
        ack_cyc   = 0;
        forever begin
            @(negedge clk);
            if (bus.wrack === 1'b1) break;
            waited++;
            if (waited > 20000) break;
        end
        if (waited > 20000) check("wrack_timeout", waited, 0);
        ack_cyc = cyc_n;
        @(posedge clk); #1;
        bus.wrreq = 1'b0;
        @(negedge clk);
        check("wrack_single_pulse", bus.wrack, 0);
    endtask

    task automatic start_dump();
        @(posedge clk); #1;
        bus.dump_start = 1'b1;
        push_snapshot();
    endtask

    // Drives dump_ready until 2048 words are accepted (or stop_addr is presented).
    task automatic consume(input bit rnd, input bit hold3, input logic [DATA_W-1:0] exp3,
                           input int stop_addr, output int busy_cycles, output int last_hs_cyc);
        int acc  = 0;
        int cyc  = 0;
        int held = 0;
        bit holding;
        bit stopped = 1'b0;
        busy_cycles = 0;
        last_hs_cyc = 0;
        while (acc < DEPTH && cyc < 30000) begin
            @(posedge clk); #1;
            bus.dump_start = 1'b0;
            holding = 1'b0;
            if (stop_addr >= 0 && bus.dump_valid && bus.dump_addr == ADDR_W'(stop_addr)) begin
                bus.dump_ready = 1'b0;
                stopped = 1'b1;
                break;
            end
            if (hold3 && bus.dump_valid && bus.dump_addr == 11'd3 && held < 10) begin
                bus.dump_ready = 1'b0;
                held++;
                holding = 1'b1;
            end else begin
                bus.dump_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (holding) begin
                check("hold_valid", bus.dump_valid, 1);
                check("hold_addr", bus.dump_addr, 3);
                check("hold_data", bus.dump_data, exp3);
            end
            if (bus.dump_busy) busy_cycles++;
            if (bus.dump_valid && bus.dump_ready) begin
                acc++;
                last_hs_cyc = cyc_n;
            end
        end
        if (stop_addr >= 0) check("dump_reached_stop_addr", stopped, 1);
        else                check("dump_words_accepted", acc, DEPTH);
        if (hold3) check("hold_cycles", held, 10);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int waited, ack_cyc, bc, last_hs, stall_ack, stall_wait;
        logic [ADDR_W-1:0] a, b;
        logic [DATA_W-1:0] d, e;

        rst_x          = 1'b0;
        bus.wrreq      = 1'b0;
        bus.waddr      = '0;
        bus.wdata      = '0;
        bus.dump_start = 1'b0;
        bus.dump_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_wrack", bus.wrack, 0);
        check("rst_dump_busy", bus.dump_busy, 0);
        check("rst_dump_valid", bus.dump_valid, 0);
        check("rst_dump_addr", bus.dump_addr, 0);
        check("rst_dump_data", bus.dump_data, 0);
        check("rst_wr_cnt", bus.wr_cnt, 0);
`ifdef MON_STALL_CNT_EN
        check("rst_stall_cnt", bus.stall_cnt, 0);
`endif
        @(posedge clk); #1;
        rst_x = 1'b1;

        // Single write: acknowledged exactly one cycle after the request.
        do_write(11'h005, 18'h1_0040, waited, ack_cyc);
        model_write(11'h005, 18'h1_0040, 1'b0);
        check("wrack_latency_first", waited, 1);
        check("wr_cnt_first", bus.wr_cnt, model_wr_cnt);

        // Fill every address so later dumps are fully predictable; word 5 keeps its value.
        for (int i = 0; i < DEPTH; i++) begin
            d = (i == 5) ? 18'h1_0040 : DATA_W'($urandom());
            do_write(ADDR_W'(i), d, waited, ack_cyc);
            model_write(ADDR_W'(i), d, 1'b0);
            check("wrack_latency", waited, 1);
            if (model_wr_cnt >= 2046) check("wr_cnt_fill", bus.wr_cnt, model_wr_cnt);
        end
        a = ADDR_W'($urandom_range(6, DEPTH - 1));
        d = DATA_W'($urandom());
        do_write(a, d, waited, ack_cyc);
        model_write(a, d, 1'b0);
        check("wr_cnt_saturated", bus.wr_cnt, 2048);

        // Full dump with ready tied high: 2 cycles per word.
        start_dump();
        consume(1'b0, 1'b0, '0, -1, bc, last_hs);
        check("dump_cycles_ready_high", bc, 4096);
        @(negedge clk);
        check("busy_after_dump", bus.dump_busy, 0);

        // Write and dump_start together: write first, dump two cycles later.
        a = ADDR_W'($urandom());
        d = DATA_W'($urandom());
        @(posedge clk); #1;
        bus.wrreq      = 1'b1;
        bus.waddr      = a;
        bus.wdata      = d;
        bus.dump_start = 1'b1;
        model_write(a, d, 1'b0);
        push_snapshot();
        @(posedge clk); #1;
        bus.dump_start = 1'b0;
        @(negedge clk);
        check("same_cycle_wrack", bus.wrack, 1);
        check("same_cycle_busy_wack", bus.dump_busy, 0);
        @(posedge clk); #1;
        bus.wrreq = 1'b0;
        @(negedge clk);
        check("same_cycle_busy_idle", bus.dump_busy, 0);
        @(negedge clk);
        check("same_cycle_busy_rise", bus.dump_busy, 1);

        // Random ready, a 10-cycle stall at address 3, and a write raised mid-dump.
        b = ADDR_W'($urandom());
        e = DATA_W'($urandom());
        fork
            consume(1'b1, 1'b1, ref_mem[3], -1, bc, last_hs);
            begin
                repeat (50) @(posedge clk);
                @(negedge clk);
                check("stall_req_during_busy", bus.dump_busy, 1);
                do_write(b, e, stall_wait, stall_ack);
            end
        join
        model_write(b, e, 1'b1);
        check("stalled_wrack_timing", stall_ack, last_hs + 2);
`ifdef MON_STALL_CNT_EN
        check("stall_cnt_one", bus.stall_cnt, model_stall);
`endif
        check("wr_cnt_still_sat", bus.wr_cnt, model_wr_cnt);

        // Reset in the middle of a dump at address 100.
        start_dump();
        consume(1'b0, 1'b0, '0, 100, bc, last_hs);
        rst_x = 1'b0;
        exp_q.delete();
        model_wr_cnt = 0;
        model_stall  = 0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_wrack", bus.wrack, 0);
        check("mid_rst_busy", bus.dump_busy, 0);
        check("mid_rst_valid", bus.dump_valid, 0);
        check("mid_rst_addr", bus.dump_addr, 0);
        check("mid_rst_data", bus.dump_data, 0);
        check("mid_rst_wr_cnt", bus.wr_cnt, model_wr_cnt);
`ifdef MON_STALL_CNT_EN
        check("mid_rst_stall_cnt", bus.stall_cnt, model_stall);
`endif
        @(posedge clk); #1;
        rst_x = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_after_rst", bus.dump_busy, 0);

        // RAM contents survive reset.
        start_dump();
        consume(1'b1, 1'b0, '0, -1, bc, last_hs);
        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
